// File: rtl/roy1707018_ro2.sv
// Selectable-length ring oscillator with a windowed rising-edge frequency counter.
// The count is read back a byte at a time; status bits are driven on the bidirectional pins.
module roy1707018_ro2 #(
  parameter int WINDOW_LOG2 = 8,
  parameter int CNT_W       = 16,
  parameter bit SIM_MODEL   = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]       CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = {WINDOW_LOG2{1'b1}};

  logic                   ro_en_s;
  logic                   start_s;
  logic [2:0]             stage_sel_s;
  logic                   byte_sel_s;
  logic                   raw_mode_s;
  logic                   ro_s;
  logic                   ro_meta_r;
  logic                   ro_sync_r;
  logic                   ro_sync_d_r;
  logic                   rise_s;
  logic                   start_d_r;
  logic                   start_pulse_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       count_nxt_s;
  logic                   overflow_r;
  logic                   overflow_nxt_s;
  logic [WINDOW_LOG2-1:0] win_r;
  logic [WINDOW_LOG2-1:0] win_nxt_s;
  logic [15:0]            count16_s;
  logic                   unused_s;

  assign ro_en_s       = ui_in[0] & ena;
  assign start_s       = ui_in[1];
  assign stage_sel_s   = ui_in[4:2];
  assign byte_sel_s    = ui_in[5];
  assign raw_mode_s    = ui_in[6];
  assign start_pulse_s = start_s & ~start_d_r & ena;
  assign rise_s        = ro_sync_r & ~ro_sync_d_r;
  assign unused_s      = ^{uio_in, ui_in[7]};

  generate
    if (SIM_MODEL) begin : g_ro_model
      logic [3:0] phase_r;
      logic       ro_r;

      // Behavioural RO: toggles every 2+stage_sel clocks, parked low with phase cleared when disabled
      always_ff @(posedge clk) begin
        if (rst_n) begin
          phase_r <= 4'd0;
          ro_r    <= 1'b0;
        end else if (!ro_en_s) begin
          phase_r <= 4'd0;
          ro_r    <= 1'b0;
        end else if (phase_r == ({1'b0, stage_sel_s} + 4'd1)) begin
          phase_r <= 4'd0;
          ro_r    <= ~ro_r;
        end else begin
          phase_r <= phase_r + 4'd1;
          ro_r    <= ro_r;
        end
      end

      assign ro_s = ro_r;
    end else begin : g_ro_ring
      // NAND gate is stage one; the tap closes the loop after 2*stage_sel+3 inversions
      (* keep *) logic [16:0] ring_s;
      logic [4:0]             tap_s;

      assign tap_s     = {1'b0, stage_sel_s, 1'b0} + 5'd2;
      assign ring_s[0] = ~(ro_en_s & ring_s[tap_s]);
      for (genvar i = 1; i < 17; i++) begin : g_inv
        assign ring_s[i] = ~ring_s[i-1];
      end
      assign ro_s = ro_en_s & ring_s[tap_s];
    end
  endgenerate

  // Two-flop synchroniser for the RO, an extra flop for edge detect, and the start edge register
  always_ff @(posedge clk) begin
    if (rst_n) begin
      ro_meta_r   <= 1'b0;
      ro_sync_r   <= 1'b0;
      ro_sync_d_r <= 1'b0;
      start_d_r   <= 1'b0;
    end else begin
      ro_meta_r   <= ro_s;
      ro_sync_r   <= ro_meta_r;
      ro_sync_d_r <= ro_sync_r;
      start_d_r   <= start_s;
    end
  end

  // Measurement state and datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r    <= ST_IDLE;
      count_r    <= {CNT_W{1'b0}};
      overflow_r <= 1'b0;
      win_r      <= {WINDOW_LOG2{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      win_r      <= win_nxt_s;
    end
  end

  // Next-state logic; losing ro_en takes priority over the window end so an aborted run never reports done
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    win_nxt_s      = win_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_pulse_s && ro_en_s) begin
          state_nxt_s    = ST_MEASURE;
          count_nxt_s    = {CNT_W{1'b0}};
          overflow_nxt_s = 1'b0;
          win_nxt_s      = {WINDOW_LOG2{1'b0}};
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_MEASURE: begin
        if (!ro_en_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          if (rise_s) begin
            if (count_r == CNT_MAX) begin
              overflow_nxt_s = 1'b1;
            end else begin
              count_nxt_s = count_r + CNT_W'(1);
            end
          end else begin
            count_nxt_s = count_r;
          end
          if (win_r == WIN_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            win_nxt_s = win_r + WINDOW_LOG2'(1);
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign count16_s = 16'(count_r);

  // Byte readback mux, legal in any state
  always_comb begin
    uo_out = 8'h00;
    if (raw_mode_s) begin
      uo_out = {ro_sync_r, 7'b0000000};
    end else if (byte_sel_s) begin
      uo_out = count16_s[15:8];
    end else begin
      uo_out = count16_s[7:0];
    end
  end

  assign uio_out = {4'b0000, overflow_r, ro_sync_r,
                    (state_r == ST_DONE), (state_r == ST_MEASURE)};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_roy1707018_ro2.sv
// Scoreboard bench for roy1707018_ro2: the stimulus queues expected measurement results,
// and a monitor checks them whenever a measurement ends (busy falls).
module tb_roy1707018_ro2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       ro_en_t, start_t, bsel_t, raw_t;
  logic [2:0] sel_t;

  typedef struct {
    bit done;
    int lo;
    int hi;
    int dur;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  assign ui_in  = {1'b0, raw_t, bsel_t, sel_t, start_t, ro_en_t};
  assign uio_in = 8'h00;

  always #5 clk = ~clk;

  roy1707018_ro2 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  task automatic chk(input string name, input bit ok, input int act, input int exp_v);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference: a square wave of period 2*(2+sel) clocks has floor or ceil(cycles/period)
  // rising edges in any window of that many consecutive clocks.
  function automatic int edges_lo(input int cycles, input int sel);
    return cycles / (2 * (2 + sel));
  endfunction

  function automatic int edges_hi(input int cycles, input int sel);
    int p;
    p = 2 * (2 + sel);
    return (cycles + p - 1) / p;
  endfunction

  // Monitor: on every busy fall, pop the oldest expectation and compare.
  initial begin
    int   dur;
    logic prev_busy;
    exp_t e;
    dur       = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (uio_out[0]) begin
        dur++;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          chk("unexpected_end", 1'b0, dur, 0);
        end else begin
          e = q.pop_front();
          chk("done_flag", uio_out[1] == e.done, int'(uio_out[1]), int'(e.done));
          chk_rng("count_lo_byte", int'(uo_out), e.lo, e.hi);
          chk("busy_cycles", dur == e.dur, dur, e.dur);
        end
        dur = 0;
      end
      prev_busy = uio_out[0];
    end
  end

  task automatic wait_end(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!uio_out[0]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // kind: 0 full window, 1 start re-pulsed mid-window, 2 ro_en dropped, 3 reset mid-window.
  // k is the number of whole measuring clocks before the disturbance.
  task automatic run_trial(input int sel, input int kind, input int k);
    exp_t e;
    bit   ok;
    int   lo, hi;
    @(posedge clk); #1;
    ro_en_t = 1'b0; sel_t = sel[2:0]; bsel_t = 1'b0; raw_t = 1'b0; start_t = 1'b0;
    repeat (2) @(posedge clk);
    #1 ro_en_t = 1'b1;
    repeat (30) @(posedge clk);
    if (kind == 2) begin
      lo = edges_lo(k, sel); hi = edges_hi(k, sel);
      e = '{done: 1'b0, lo: lo, hi: hi, dur: k + 1};
    end else if (kind == 3) begin
      lo = 0; hi = 0;
      e = '{done: 1'b0, lo: 0, hi: 0, dur: k + 1};
    end else begin
      lo = edges_lo(256, sel); hi = edges_hi(256, sel);
      e = '{done: 1'b1, lo: lo, hi: hi, dur: 256};
    end
    q.push_back(e);
    #1 start_t = 1'b1;
    @(posedge clk); #1 start_t = 1'b0;
    @(negedge clk);
    chk("count_cleared_on_start", uo_out == 8'h00, int'(uo_out), 0);
    if (kind == 1) begin
      repeat (k) @(posedge clk);
      #1 start_t = 1'b1;
      @(posedge clk); #1 start_t = 1'b0;
    end else if (kind == 2) begin
      repeat (k) @(posedge clk);
      #1 ro_en_t = 1'b0;
    end else if (kind == 3) begin
      repeat (k) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1 rst_n = 1'b0;
    end
    wait_end(ok);
    chk("window_end_seen", ok, int'(ok), 1);
    if (kind != 3) begin
      @(posedge clk); #1 bsel_t = 1'b1;
      @(negedge clk);
      chk("count_hi_byte", uo_out == 8'(hi >> 8), int'(uo_out), hi >> 8);
      chk("overflow_clear", uio_out[3] == 1'b0, int'(uio_out[3]), 0);
      @(posedge clk); #1 bsel_t = 1'b0;
      repeat (5) @(negedge clk);
      chk_rng("count_frozen", int'(uo_out), lo, hi);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int toggles;
    bit bad_raw;
    logic prev_bit;
    int sel, kind, k;

    // Reset with arbitrary inputs held for five clocks
    rst_n = 1'b1; ena = 1'b1;
    ro_en_t = 1'($urandom); start_t = 1'b0; bsel_t = 1'($urandom);
    raw_t = 1'($urandom); sel_t = 3'($urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_uo_out", uo_out == 8'h00, int'(uo_out), 0);
    chk("reset_uio_out", uio_out == 8'h00, int'(uio_out), 0);
    chk("reset_uio_oe", uio_oe == 8'h0F, int'(uio_oe), 15);
    @(posedge clk); #1;
    rst_n = 1'b0; ro_en_t = 1'b0; bsel_t = 1'b0; raw_t = 1'b0; sel_t = 3'd0;

    // ena=0 blocks both the RO and the start pulse
    repeat (2) @(posedge clk);
    #1 ena = 1'b0; ro_en_t = 1'b1;
    @(posedge clk); #1 start_t = 1'b1;
    @(posedge clk); #1 start_t = 1'b0;
    repeat (10) @(negedge clk);
    chk("ena0_no_busy", uio_out == 8'h00, int'(uio_out), 0);
    @(posedge clk); #1 ena = 1'b1;

    // raw mode shows the synchronised RO on bit 7 only
    raw_t = 1'b1; sel_t = 3'd0;
    repeat (10) @(negedge clk);
    toggles = 0; bad_raw = 1'b0; prev_bit = uo_out[7];
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (uo_out[6:0] != 7'd0 || uo_out[7] != uio_out[2]) bad_raw = 1'b1;
      if (uo_out[7] != prev_bit) toggles++;
      prev_bit = uo_out[7];
    end
    chk("raw_low_bits_zero", !bad_raw, int'(bad_raw), 0);
    chk_rng("raw_toggles", toggles, 18, 21);
    @(posedge clk); #1 raw_t = 1'b0;

    // Directed measurements
    run_trial(0, 0, 0);
    run_trial(3, 0, 0);
    run_trial(3, 2, 99);
    run_trial(1, 1, 128);
    run_trial(2, 0, 0);
    run_trial(5, 3, 50);
    run_trial(7, 0, 0);

    // Randomised measurements
    for (int t = 0; t < 20; t++) begin
      sel  = int'($urandom_range(0, 7));
      kind = int'($urandom_range(0, 3));
      k    = int'($urandom_range(20, 200));
      run_trial(sel, kind, k);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", q.size() == 0, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
